o_ddr_serializer: RTL

//  Parametrised output serializer. Accepts a WIDTH-bit parallel word over a

---
 rtl/o_ddr_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/o_ddr_serializer.sv
// -----------------------------------------------------------------------------
// o_ddr_serializer
//   Output serializer between fabric TX logic and an output pad. A WIDTH-bit
//   parallel word is taken over a valid/ready handshake and shifted out
//   LSB-first on the single output Q. In DDR mode two bits leave per clock
//   (rising-edge phase first, then falling-edge phase); otherwise one bit per
//   clock. Consecutive words are sent without gaps when the next word is
//   offered in time; otherwise Q drops to IDLE_VALUE and UNDERRUN pulses.
//
// Parameters
//   WIDTH      parallel word width, 2..16, even when DDR_MODE=1
//   DDR_MODE   1: two bits per clock, 0: one bit per clock
//   IDLE_VALUE level on Q while no word is in flight
//
// Ports
//   C         in   clock; all state on the rising edge except the fall-phase bit
//   R         in   synchronous reset, active low, sampled on rising C
//   E         in   enable; 0 freezes all state
//   D         in   parallel data word
//   D_VALID   in   D holds a word to send
//   D_READY   out  word accepted on the rising edge where D_VALID & D_READY
//   Q         out  serial output
//   UNDERRUN  out  one-cycle pulse after a word ends with no successor
// -----------------------------------------------------------------------------
module o_ddr_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   DDR_MODE   = 1,
    parameter logic IDLE_VALUE = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             Q,
    output logic             UNDERRUN
);

    // Bits launched per clock and number of launches (slots) per word.
    localparam int BPC = (DDR_MODE != 0) ? 2 : 1;
    localparam int N   = WIDTH / BPC;
    localparam int RW  = $clog2(N + 1);

    localparam logic [RW-1:0] N_RW   = RW'(N);
    localparam logic [RW-1:0] ONE_RW = RW'(1);

    logic [WIDTH-1:0] r_shreg;     // unsent bits, next slot in the low bits
    logic [RW-1:0]    r_rem;       // slots still to launch for the current word
    logic             r_active;    // last launch carried data
    logic             r_p0;        // rise-phase bit of the current slot
    logic             r_p1;        // fall-phase bit of the current slot
    logic             r_n1;        // r_p1 retimed to the falling edge
    logic             r_underrun;

    logic             w_ready;
    logic             w_accept;
    logic             w_busy;

    // A new word may be loaded while the last slot of the previous one is
    // being launched, which is what makes back-to-back words gapless.
    assign w_ready  = R & E & (r_rem <= ONE_RW);
    assign w_accept = w_ready & D_VALID;
    assign w_busy   = (r_rem != {RW{1'b0}});

    // Slot launch, word load, and underrun detection on the rising edge.
    always_ff @(posedge C) begin
        if (!R) begin
            r_shreg    <= {WIDTH{1'b0}};
            r_rem      <= {RW{1'b0}};
            r_active   <= 1'b0;
            r_p0       <= 1'b0;
            r_p1       <= 1'b0;
            r_underrun <= 1'b0;
        end else if (E) begin
            if (w_busy) begin
                r_p0       <= r_shreg[0];
                // In SDR mode BPC-1 is 0, so both phases carry the same bit.
                r_p1       <= r_shreg[BPC-1];
                r_shreg    <= r_shreg >> BPC;
                r_rem      <= r_rem - ONE_RW;
                r_active   <= 1'b1;
                r_underrun <= 1'b0;
            end else begin
                r_p0       <= IDLE_VALUE;
                r_p1       <= IDLE_VALUE;
                r_active   <= 1'b0;
                // Idle launched right after data: the source fell behind.
                r_underrun <= r_active;
            end
            // Loading overrides the shift/decrement made above.
            if (w_accept) begin
                r_shreg <= D;
                r_rem   <= N_RW;
            end else begin
                r_shreg <= w_busy ? (r_shreg >> BPC) : r_shreg;
                r_rem   <= w_busy ? (r_rem - ONE_RW) : r_rem;
            end
        end else begin
            r_underrun <= 1'b0;
        end
    end

    // Fall-phase bit: retimed so it only reaches Q while C is low.
    always_ff @(negedge C) begin
        r_n1 <= r_p1;
    end

    // Output mux: the clock level selects which half of the slot is on Q.
    assign Q        = (DDR_MODE != 0) ? (C ? r_p0 : r_n1) : r_p0;
    assign D_READY  = w_ready;
    assign UNDERRUN = r_underrun;

endmodule
